// File: rtl/av2_mv_encoder.sv
// Motion-vector symbol encoder: emits LSB-first magnitude symbols then a sign symbol, X before Y.
// Optional statistics counters are compiled in with `define AV2_MV_ENC_STATS_EN.
module av2_mv_encoder #(
    parameter int MAG_BITS = 12,
    parameter int CTX_BASE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mv_x,
    input  logic [15:0] mv_y,
    input  logic        mv_valid,
    output logic        mv_ready,
    output logic [15:0] symbol,
    output logic [15:0] symbol_ctx,
    output logic        symbol_valid,
    input  logic        symbol_ready,
    output logic        busy,
    output logic        done
`ifdef AV2_MV_ENC_STATS_EN
    ,
    output logic [31:0] stat_mv_count,
    output logic [31:0] stat_sym_count,
    output logic [15:0] stat_sat_count
`endif
);

    typedef enum logic [2:0] {IDLE, MAG_X, SIGN_X, MAG_Y, SIGN_Y, DONE} state_t;

    localparam logic [16:0] MAG_MAX  = 17'((1 << MAG_BITS) - 1);
    localparam logic [3:0]  IDX_LAST = 4'(MAG_BITS - 1);

    // 17-bit absolute value so that -32768 is representable before saturation.
    function automatic logic [16:0] abs17(input logic [15:0] v);
        return v[15] ? (17'd0 - {v[15], v}) : {1'b0, v};
    endfunction

    function automatic logic [MAG_BITS-1:0] sat_mag(input logic [15:0] v);
        logic [16:0] a;
        a = abs17(v);
        return (a > MAG_MAX) ? MAG_MAX[MAG_BITS-1:0] : a[MAG_BITS-1:0];
    endfunction

    state_t              state, state_d;
    logic [3:0]          idx, idx_d;
    logic [MAG_BITS-1:0] mag_x, mag_x_d, mag_y, mag_y_d;
    logic                sign_x, sign_x_d, sign_y, sign_y_d;
    logic [15:0]         symbol_d, symbol_ctx_d;
    logic                symbol_valid_d, mv_ready_d, busy_d, done_d;
    logic                accept, handshake;

    assign accept    = (state == IDLE) && mv_valid && mv_ready;
    assign handshake = symbol_valid && symbol_ready;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            mag_x        <= '0;
            mag_y        <= '0;
            sign_x       <= 1'b0;
            sign_y       <= 1'b0;
            symbol       <= '0;
            symbol_ctx   <= '0;
            symbol_valid <= 1'b0;
            mv_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state        <= state_d;
            idx          <= idx_d;
            mag_x        <= mag_x_d;
            mag_y        <= mag_y_d;
            sign_x       <= sign_x_d;
            sign_y       <= sign_y_d;
            symbol       <= symbol_d;
            symbol_ctx   <= symbol_ctx_d;
            symbol_valid <= symbol_valid_d;
            mv_ready     <= mv_ready_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d  = state;
        idx_d    = idx;
        mag_x_d  = mag_x;
        mag_y_d  = mag_y;
        sign_x_d = sign_x;
        sign_y_d = sign_y;
        unique case (state)
            IDLE: if (accept) begin
                mag_x_d  = sat_mag(mv_x);
                mag_y_d  = sat_mag(mv_y);
                sign_x_d = mv_x[15];
                sign_y_d = mv_y[15];
                idx_d    = '0;
                state_d  = MAG_X;
            end
            MAG_X, MAG_Y: if (handshake) begin
                if (symbol == 16'd0 || idx == IDX_LAST)
                    state_d = (state == MAG_X) ? SIGN_X : SIGN_Y;
                else
                    idx_d = idx + 4'd1;
            end
            SIGN_X: if (handshake) begin
                idx_d   = '0;
                state_d = MAG_Y;
            end
            SIGN_Y: if (handshake) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the next state, so a stall reproduces the held symbol.
    always_comb begin
        symbol_d       = '0;
        symbol_ctx_d   = '0;
        symbol_valid_d = 1'b0;
        mv_ready_d     = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        unique case (state_d)
            IDLE: mv_ready_d = 1'b1;
            MAG_X: begin
                symbol_d       = 16'(mag_x_d) & (16'hFFFF << idx_d);
                symbol_ctx_d   = 16'(CTX_BASE) + 16'(idx_d);
                symbol_valid_d = 1'b1;
                busy_d         = 1'b1;
            end
            SIGN_X: begin
                symbol_d       = {15'd0, sign_x_d};
                symbol_ctx_d   = 16'(CTX_BASE) + 16'd32;
                symbol_valid_d = 1'b1;
                busy_d         = 1'b1;
            end
            MAG_Y: begin
                symbol_d       = 16'(mag_y_d) & (16'hFFFF << idx_d);
                symbol_ctx_d   = 16'(CTX_BASE) + 16'd16 + 16'(idx_d);
                symbol_valid_d = 1'b1;
                busy_d         = 1'b1;
            end
            SIGN_Y: begin
                symbol_d       = {15'd0, sign_y_d};
                symbol_ctx_d   = 16'(CTX_BASE) + 16'd33;
                symbol_valid_d = 1'b1;
                busy_d         = 1'b1;
            end
            DONE: done_d = 1'b1;
            default: mv_ready_d = 1'b0;
        endcase
    end

`ifdef AV2_MV_ENC_STATS_EN
    logic [1:0] sat_inc;
    assign sat_inc = accept ? (2'((abs17(mv_x) > MAG_MAX)) + 2'((abs17(mv_y) > MAG_MAX))) : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_mv_count  <= '0;
            stat_sym_count <= '0;
            stat_sat_count <= '0;
        end else begin
            if (state == DONE && stat_mv_count != 32'hFFFF_FFFF)
                stat_mv_count <= stat_mv_count + 32'd1;
            if (handshake && stat_sym_count != 32'hFFFF_FFFF)
                stat_sym_count <= stat_sym_count + 32'd1;
            if (stat_sat_count > 16'hFFFF - 16'(sat_inc))
                stat_sat_count <= 16'hFFFF;
            else
                stat_sat_count <= stat_sat_count + 16'(sat_inc);
        end
    end
`endif

endmodule
